// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Macro BIN2BCD_DUAL_STEP_EN (used by bin2bcd_seq_ctrl) selects two steps per cycle.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int DIGITS     = 6;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_ADD    = 3;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bin2bcd_step.sv
// One double-dabble step: add-3 adjust on every BCD nibble, then shift the
// {bcd, bin} working register left by one. ovf flags a set bit leaving the top.
module bin2bcd_step
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH_bin = 20,
    parameter int WIDTH_bcd = 24
) (
    input  logic [WIDTH_bcd-1:0] bcd_cur,
    input  logic [WIDTH_bin-1:0] bin_cur,
    output logic [WIDTH_bcd-1:0] bcd_next,
    output logic [WIDTH_bin-1:0] bin_next,
    output logic                 ovf
);

    localparam int NDIG = WIDTH_bcd / 4;

    logic [WIDTH_bcd-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_cur;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_cur[4*i +: 4] >= 4'(ADJ_THRESH)) begin
                bcd_adj[4*i +: 4] = bcd_cur[4*i +: 4] + 4'(ADJ_ADD);
            end
        end
    end

    assign ovf = bcd_adj[WIDTH_bcd-1];
    assign {bcd_next, bin_next} = {bcd_adj[WIDTH_bcd-2:0], bin_cur, 1'b0};

endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// Iterative binary-to-BCD controller with valid/ready on both sides.
// Define BIN2BCD_DUAL_STEP_EN to chain two double-dabble steps per cycle.
module bin2bcd_seq_ctrl
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH_bin = 20,
    parameter int WIDTH_bcd = 4 * DIGITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_bin-1:0] in_bin,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_bcd-1:0] out_bcd,
    output logic                 out_ovf,
    output logic                 busy
);

    localparam int CNT_W = (clog2(WIDTH_bin) < 1) ? 1 : clog2(WIDTH_bin);
`ifdef BIN2BCD_DUAL_STEP_EN
    localparam int CONV_CYCLES = (WIDTH_bin + 1) / 2;
`else
    localparam int CONV_CYCLES = WIDTH_bin;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CONV_CYCLES - 1);

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH_bcd-1:0] bcd_q;
    logic [WIDTH_bin-1:0] bin_q;
    logic                 ovf_q;

    logic [WIDTH_bcd-1:0] bcd_s1;
    logic [WIDTH_bin-1:0] bin_s1;
    logic                 ovf_s1;
    logic [WIDTH_bcd-1:0] bcd_nxt;
    logic [WIDTH_bin-1:0] bin_nxt;
    logic                 ovf_nxt;

    bin2bcd_step #(.WIDTH_bin(WIDTH_bin), .WIDTH_bcd(WIDTH_bcd)) u_step0 (
        .bcd_cur  (bcd_q),
        .bin_cur  (bin_q),
        .bcd_next (bcd_s1),
        .bin_next (bin_s1),
        .ovf      (ovf_s1)
    );

`ifdef BIN2BCD_DUAL_STEP_EN
    logic [WIDTH_bcd-1:0] bcd_s2;
    logic [WIDTH_bin-1:0] bin_s2;
    logic                 ovf_s2;

    bin2bcd_step #(.WIDTH_bin(WIDTH_bin), .WIDTH_bcd(WIDTH_bcd)) u_step1 (
        .bcd_cur  (bcd_s1),
        .bin_cur  (bin_s1),
        .bcd_next (bcd_s2),
        .bin_next (bin_s2),
        .ovf      (ovf_s2)
    );

    // With an odd width the last cycle has only one step left to do.
    always_comb begin
        bcd_nxt = bcd_s2;
        bin_nxt = bin_s2;
        ovf_nxt = ovf_s1 | ovf_s2;
        if ((WIDTH_bin % 2 == 1) && (cnt == LAST)) begin
            bcd_nxt = bcd_s1;
            bin_nxt = bin_s1;
            ovf_nxt = ovf_s1;
        end
    end
`else
    assign bcd_nxt = bcd_s1;
    assign bin_nxt = bin_s1;
    assign ovf_nxt = ovf_s1;
`endif

    // The result registers double as the working register.
    assign out_bcd  = bcd_q;
    assign out_ovf  = ovf_q;
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bcd_q <= '0;
                        bin_q <= in_bin;
                        ovf_q <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_nxt;
                    bin_q <= bin_nxt;
                    ovf_q <= ovf_q | ovf_nxt;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            bcd_q <= '0;
                            bin_q <= in_bin;
                            ovf_q <= 1'b0;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= CONV;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/bin2bcd_seq_ctrl.md
Name: bin2bcd_seq_ctrl

Overview:
Iterative binary-to-BCD converter controller for the VGA digital clock display path. Accepts one binary word per valid/ready handshake and runs a double-dabble step (adjust then shift) once per clock for WIDTH_bin cycles. Presents packed BCD digits to the character/segment renderer under a valid/ready handshake. Replaces the fully unrolled combinational converter, trading latency for area.

Parameters:
WIDTH_bin, 20, binary input width in bits (>=2)
WIDTH_bcd, 24, BCD output width in bits (multiple of 4; digits = WIDTH_bcd/4)

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_bin is valid
in_ready  output  1  block can accept in_bin this cycle
in_bin  input  WIDTH_bin  binary value to convert
out_valid  output  1  out_bcd/out_ovf are valid
out_ready  input  1  consumer accepts the result
out_bcd  output  WIDTH_bcd  packed BCD result; digit 0 in bits [3:0]
out_ovf  output  1  value exceeded 10^(WIDTH_bcd/4)-1; out_bcd holds the low digits
busy  output  1  high in CONV

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_bcd=0, out_ovf=0, busy=0, step counter=0.
- Working register: {bcd[WIDTH_bcd-1:0], bin[WIDTH_bin-1:0]}, plus sticky ovf flag.
- State IDLE:
  - in_ready=1.
  - On in_valid: load bcd=0, bin=in_bin, ovf=0, cnt=0. Go to CONV.
- State CONV:
  - in_ready=0, busy=1.
  - Each cycle apply one step: for each BCD nibble, add 3 if the nibble is >=5. Then shift the whole register left 1, with bin MSB entering bcd LSB.
  - If the adjusted top nibble has bit3 set before the shift, set ovf (sticky).
  - cnt increments. When cnt==WIDTH_bin-1, the last step executes. Go to DONE.
  - Latency: the handshake edge plus exactly WIDTH_bin cycles in CONV; out_valid is high on the following cycle.
- State DONE:
  - out_valid=1; out_bcd and out_ovf are held stable until accepted.
  - in_ready = out_ready.
  - out_ready=1 and in_valid=1: the result is consumed and the new input is loaded in the same cycle. Go to CONV with no bubble.
  - out_ready=1 and in_valid=0: go to IDLE; out_valid drops next cycle.
  - out_ready=0: hold the state; in_valid is ignored.
- in_valid during CONV is ignored; the source holds the value because in_ready=0.
- rst asserted in any state, including mid-conversion: the partial result is discarded and all reset values apply next cycle.
- The counter width is clog2(WIDTH_bin). The counter never wraps because the exit is on the terminal compare.

Optional Feature:
- Macro: BIN2BCD_DUAL_STEP_EN.
- Defined:
  - Two chained steps per cycle.
  - CONV lasts ceil(WIDTH_bin/2) cycles.
  - For odd WIDTH_bin, the final cycle performs a single step.
  - ovf is checked at both steps.
- Undefined: one step per cycle, as above.
- Results are bit-identical either way.

Decomposition:
- Package bin2bcd_pkg:
  - state enum {IDLE, CONV, DONE}
  - function clog2
  - localparam DIGITS = WIDTH_bcd/4
  - constant ADJ_THRESH=5, ADJ_ADD=3
- One sub-module, bin2bcd_step: combinational single adjust-then-shift over the working register, with an ovf output.
  - The controller instantiates it once, or twice chained under BIN2BCD_DUAL_STEP_EN.

Test Plan:
- in_bin=20'd0 -> out_valid exactly 21 cycles after the accept edge; out_bcd=24'h000000, out_ovf=0.
- in_bin=20'd999999 -> out_bcd=24'h999999, out_ovf=0. in_bin=20'd86399 -> out_bcd=24'h086399.
- in_bin=20'hFFFFF (1048575) -> out_bcd=24'h048575, out_ovf=1. in_bin=20'd1000000 -> out_bcd=24'h000000, out_ovf=1.
- out_ready held 0 for 10 cycles in DONE -> out_bcd stable, in_ready=0. Then out_ready=1 with in_valid=1 (in_bin=20'd59) -> back-to-back accept; next result is 24'h000059.
- rst pulsed for 1 cycle at step 7 of CONV -> next cycle: state IDLE, out_valid=0, in_ready=1. A subsequent conversion of 20'd12345 yields 24'h012345.
- Both macro settings with WIDTH_bin=20 and with WIDTH_bin=7: random sweep against a reference model; CONV cycle count is 20/10 and 7/4 respectively.
